// File: rtl/alu_share_if.sv
// Bundle of requester, response and ALU-side signals for alu_share_ctrl.
// The "slave" modport is the controller itself. The "master" modport is
// everything around it: the two requesters plus the shared ALU.
// Handshake rule for every channel: a transfer happens on a rising clk
// edge where valid && ready are both 1. The source holds valid and payload
// stable until that edge. Ready may depend combinationally on valid.
interface alu_share_if #(
    parameter int DW  = 8,
    parameter int OPW = 5
);
    logic           req0_valid;
    logic           req0_ready;
    logic [OPW-1:0] req0_op;
    logic [DW-1:0]  req0_a;
    logic [DW-1:0]  req0_b;
    logic [DW-1:0]  req0_lit;

    logic           req1_valid;
    logic           req1_ready;
    logic [OPW-1:0] req1_op;
    logic [DW-1:0]  req1_a;
    logic [DW-1:0]  req1_b;
    logic [DW-1:0]  req1_lit;

    logic           rsp0_valid;
    logic           rsp0_ready;
    logic [DW-1:0]  rsp0_data;
    logic           rsp0_err;

    logic           rsp1_valid;
    logic           rsp1_ready;
    logic [DW-1:0]  rsp1_data;
    logic           rsp1_err;

    logic           alu_rst;
    logic [OPW-1:0] alu_op;
    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic [DW-1:0]  alu_lit;
    logic [DW-1:0]  alu_c;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_lit,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b, req1_lit,
        output req1_ready,
        output rsp0_valid, rsp0_data, rsp0_err,
        input  rsp0_ready,
        output rsp1_valid, rsp1_data, rsp1_err,
        input  rsp1_ready,
        output alu_rst, alu_op, alu_a, alu_b, alu_lit,
        input  alu_c
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_lit,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b, req1_lit,
        input  req1_ready,
        input  rsp0_valid, rsp0_data, rsp0_err,
        output rsp0_ready,
        input  rsp1_valid, rsp1_data, rsp1_err,
        output rsp1_ready,
        input  alu_rst, alu_op, alu_a, alu_b, alu_lit,
        output alu_c
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: arbitrates two requesters onto one shared combinational
// ALU. It runs one operation at a time in three steps:
//   IDLE - accept a request
//   EXEC - drive the ALU for one cycle
//   RESP - return the result to the requester that won the grant
// Optional macro ALU_SHARE_RR_EN: selects round-robin arbitration. When
// the macro is undefined, arbitration is fixed priority (requester 0 wins).
// Reset: rst, synchronous, active-low.
module alu_share_ctrl #(
    parameter int DW  = 8,
    parameter int OPW = 5
) (
    input  logic        clk,
    input  logic        rst,
    alu_share_if.slave  bus,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;

    logic           grant_idx;
    logic           accept;
    logic [OPW-1:0] sel_op;
    logic [DW-1:0]  sel_a;
    logic [DW-1:0]  sel_b;
    logic [DW-1:0]  sel_lit;
    logic           sel_legal;
    logic           rsp_taken;

    logic [OPW-1:0] op_q;
    logic [DW-1:0]  a_q;
    logic [DW-1:0]  b_q;
    logic [DW-1:0]  lit_q;
    logic           grant_q;
    logic [DW-1:0]  data_q;
    logic           err_q;

`ifdef ALU_SHARE_RR_EN
    logic           ptr_q;
`endif

    // Op 0x08 is rejected on purpose. Its result would depend on the
    // previous op, and that op may have come from the other requester.
    function automatic logic op_legal(input logic [OPW-1:0] op);
        int unsigned v;
        v = 32'(op);
        return (v >= 32'h01 && v <= 32'h07) ||
               (v >= 32'h11 && v <= 32'h13) ||
               (v >= 32'h15 && v <= 32'h17);
    endfunction

    // Pick the winner among asserted valids, then select its payload.
    always_comb begin
`ifdef ALU_SHARE_RR_EN
        if (bus.req0_valid && bus.req1_valid) begin
            grant_idx = ptr_q;
        end else begin
            grant_idx = bus.req1_valid;
        end
`else
        grant_idx = !bus.req0_valid && bus.req1_valid;
`endif
        sel_op    = grant_idx ? bus.req1_op  : bus.req0_op;
        sel_a     = grant_idx ? bus.req1_a   : bus.req0_a;
        sel_b     = grant_idx ? bus.req1_b   : bus.req0_b;
        sel_lit   = grant_idx ? bus.req1_lit : bus.req0_lit;
        sel_legal = op_legal(sel_op);
        // Ready is held low while rst is asserted, even on the first
        // reset edge, before the state register has been cleared.
        accept    = rst && (state == IDLE) && (bus.req0_valid || bus.req1_valid);
        rsp_taken = grant_q ? bus.rsp1_ready : bus.rsp0_ready;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. An illegal op skips EXEC, so the ALU is never touched.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = sel_legal ? EXEC : RESP;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                if (rsp_taken) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Latch the accepted request, then capture the ALU result at the end of EXEC.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            lit_q   <= '0;
            grant_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
`ifdef ALU_SHARE_RR_EN
            ptr_q   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                op_q    <= sel_op;
                a_q     <= sel_a;
                b_q     <= sel_b;
                lit_q   <= sel_lit;
                grant_q <= grant_idx;
                err_q   <= !sel_legal;
                data_q  <= '0;
`ifdef ALU_SHARE_RR_EN
                ptr_q   <= !grant_idx;
`endif
            end
            if (state == EXEC) begin
                data_q <= bus.alu_c;
            end
        end
    end

    // Outputs are decoded from the state. The ALU lines sit at zero outside
    // EXEC, and the response lines carry data only for the granted requester.
    always_comb begin
        bus.req0_ready = accept && !grant_idx;
        bus.req1_ready = accept && grant_idx;

        bus.rsp0_valid = (state == RESP) && !grant_q;
        bus.rsp1_valid = (state == RESP) && grant_q;
        bus.rsp0_data  = bus.rsp0_valid ? data_q : '0;
        bus.rsp1_data  = bus.rsp1_valid ? data_q : '0;
        bus.rsp0_err   = bus.rsp0_valid && err_q;
        bus.rsp1_err   = bus.rsp1_valid && err_q;

        bus.alu_op     = (state == EXEC) ? op_q  : '0;
        bus.alu_a      = (state == EXEC) ? a_q   : '0;
        bus.alu_b      = (state == EXEC) ? b_q   : '0;
        bus.alu_lit    = (state == EXEC) ? lit_q : '0;

        dbg_state      = state;
    end

    assign bus.alu_rst = rst;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed testbench for alu_share_ctrl. Inputs change on the falling clk
// edge. Outputs are sampled on the falling edge (registered values) or 1 ns
// later (values decoded combinationally from the new inputs).
// The ALU is modelled here. Codes that are not real ops return 0xA5, so a
// result captured in the wrong cycle shows up as a wrong value.
module tb_alu_share_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0] dbg_state;
    int n_tests = 0;
    int n_fail  = 0;

    alu_share_if #(.DW(8), .OPW(5)) bus ();

    alu_share_ctrl #(.DW(8), .OPW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock: 10 ns period.
    always #5 clk = ~clk;

    // Shared-ALU model.
    always_comb begin
        case (bus.alu_op)
            5'h01:   bus.alu_c = bus.alu_a + bus.alu_b;
            5'h02:   bus.alu_c = bus.alu_a - bus.alu_b;
            5'h03:   bus.alu_c = bus.alu_a & bus.alu_b;
            5'h11:   bus.alu_c = bus.alu_a + bus.alu_lit;
            5'h12:   bus.alu_c = bus.alu_a - bus.alu_lit;
            5'h13:   bus.alu_c = bus.alu_a ^ bus.alu_lit;
            default: bus.alu_c = 8'hA5;
        endcase
    end

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one requester's valid and payload.
    task automatic set_req(input bit idx, input bit valid, input logic [4:0] op,
                           input logic [7:0] a, input logic [7:0] b, input logic [7:0] lit);
        if (idx) begin
            bus.req1_valid = valid; bus.req1_op = op;
            bus.req1_a = a; bus.req1_b = b; bus.req1_lit = lit;
        end else begin
            bus.req0_valid = valid; bus.req0_op = op;
            bus.req0_a = a; bus.req0_b = b; bus.req0_lit = lit;
        end
    endtask

    // Run one complete operation on requester idx, with rsp_ready held at 1.
    task automatic do_op(input string tag, input bit idx, input logic [4:0] op,
                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] lit,
                         input bit legal, input logic [7:0] exp_data);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        set_req(idx, 1'b1, op, a, b, lit);
        #1;
        check({tag, "_ready"}, idx ? bus.req1_ready : bus.req0_ready, 1);
        check({tag, "_other_ready"}, idx ? bus.req0_ready : bus.req1_ready, 0);
        check({tag, "_alu_op_idle"}, bus.alu_op, 0);
        @(negedge clk);
        set_req(idx, 1'b0, 5'h00, 8'h00, 8'h00, 8'h00);
        if (legal) begin
            check({tag, "_state_exec"}, dbg_state, 1);
            check({tag, "_alu_op"}, bus.alu_op, op);
            check({tag, "_alu_a"}, bus.alu_a, a);
            check({tag, "_alu_b"}, bus.alu_b, b);
            check({tag, "_alu_lit"}, bus.alu_lit, lit);
            @(negedge clk);
        end
        check({tag, "_state_resp"}, dbg_state, 2);
        check({tag, "_alu_op_resp"}, bus.alu_op, 0);
        check({tag, "_rsp_valid"}, idx ? bus.rsp1_valid : bus.rsp0_valid, 1);
        check({tag, "_rsp_other_valid"}, idx ? bus.rsp0_valid : bus.rsp1_valid, 0);
        check({tag, "_rsp_data"}, idx ? bus.rsp1_data : bus.rsp0_data, exp_data);
        check({tag, "_rsp_err"}, idx ? bus.rsp1_err : bus.rsp0_err, !legal);
        @(negedge clk);
        check({tag, "_state_idle"}, dbg_state, 0);
        check({tag, "_rsp_done"}, idx ? bus.rsp1_valid : bus.rsp0_valid, 0);
    endtask

    initial begin
        bit            both_ready;
        int            n0;
        int            n1;
        int            n_rsp;
        bit            order_q[$];
        logic [7:0]    exp_q[$];
        bit            exp_idx_q[$];
        logic [1:0]    got;
        logic [7:0]    exp_d;
        bit            exp_i;

        set_req(0, 1'b0, 5'h00, 8'h00, 8'h00, 8'h00);
        set_req(1, 1'b0, 5'h00, 8'h00, 8'h00, 8'h00);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;

        // Reset held for three cycles, with both valids high.
        rst = 1'b0;
        set_req(0, 1'b1, 5'h01, 8'h01, 8'h01, 8'h00);
        set_req(1, 1'b1, 5'h01, 8'h02, 8'h02, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("rst_ready0", bus.req0_ready, 0);
            check("rst_ready1", bus.req1_ready, 0);
            check("rst_rsp0_valid", bus.rsp0_valid, 0);
            check("rst_rsp1_valid", bus.rsp1_valid, 0);
            check("rst_rsp0_data", bus.rsp0_data, 0);
            check("rst_alu_op", bus.alu_op, 0);
            check("rst_alu_a", bus.alu_a, 0);
            check("rst_alu_rst", bus.alu_rst, 0);
            check("rst_state", dbg_state, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        set_req(0, 1'b0, 5'h00, 8'h00, 8'h00, 8'h00);
        set_req(1, 1'b0, 5'h00, 8'h00, 8'h00, 8'h00);
        #1;
        check("run_alu_rst", bus.alu_rst, 1);

        // Single op: 0x7F + 0x02 = 0x81.
        do_op("single", 1'b0, 5'h01, 8'h7F, 8'h02, 8'h00, 1'b1, 8'h81);
        // Wrap: 0x03 - 0x05 = 0xFE. Then 0x10 ^ 0x10 = 0x00.
        do_op("wrap_sub", 1'b1, 5'h12, 8'h03, 8'h00, 8'h05, 1'b1, 8'hFE);
        do_op("wrap_zero", 1'b1, 5'h13, 8'h10, 8'h00, 8'h10, 1'b1, 8'h00);
        // Rejected ops 0x08 and 0x14: err=1 and data=0x00, and the ALU is never driven.
        do_op("rej_08", 1'b0, 5'h08, 8'h55, 8'h66, 8'h77, 1'b0, 8'h00);
        do_op("rej_14", 1'b0, 5'h14, 8'h55, 8'h66, 8'h77, 1'b0, 8'h00);
        // Edge of the legal ranges.
        do_op("edge_02", 1'b0, 5'h02, 8'h00, 8'h01, 8'h00, 1'b1, 8'hFF);
        do_op("rej_18", 1'b1, 5'h18, 8'h01, 8'h01, 8'h01, 1'b0, 8'h00);

        // One reset cycle, so the RR pointer starts at 0 for the contention run.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Contention: both requesters keep valid high for 4 ops each.
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        both_ready = 1'b0;
        n0 = 0;
        n1 = 0;
        n_rsp = 0;
        for (int cyc = 0; cyc < 60 && n_rsp < 8; cyc++) begin
            set_req(0, n0 < 4, 5'h01, 8'h10 + 8'(n0), 8'h01, 8'h00);
            set_req(1, n1 < 4, 5'h11, 8'h20 + 8'(n1), 8'h00, 8'h02);
            #1;
            if (bus.req0_ready && bus.req1_ready) both_ready = 1'b1;
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                check("cont_rsp_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_d = exp_q.pop_front();
                    exp_i = exp_idx_q.pop_front();
                    check("cont_rsp_idx", bus.rsp1_valid, exp_i);
                    check("cont_rsp_data", exp_i ? bus.rsp1_data : bus.rsp0_data, exp_d);
                end
                n_rsp++;
            end
            if (bus.req0_ready) begin
                order_q.push_back(1'b0);
                exp_q.push_back(8'h11 + 8'(n0));
                exp_idx_q.push_back(1'b0);
                n0++;
            end else if (bus.req1_ready) begin
                order_q.push_back(1'b1);
                exp_q.push_back(8'h22 + 8'(n1));
                exp_idx_q.push_back(1'b1);
                n1++;
            end
            @(negedge clk);
        end
        check("cont_all_rsp", n_rsp, 8);
        check("cont_one_ready", both_ready, 0);
        for (int i = 0; i < 8; i++) begin
            got = (order_q.size() > i) ? {1'b0, order_q[i]} : 2'd2;
`ifdef ALU_SHARE_RR_EN
            check($sformatf("cont_grant_%0d", i), got, i % 2);
`else
            check($sformatf("cont_grant_%0d", i), got, (i >= 4) ? 1 : 0);
`endif
        end
        set_req(0, 1'b0, 5'h00, 8'h00, 8'h00, 8'h00);
        set_req(1, 1'b0, 5'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);

        // Backpressure, then reset in the middle of RESP. 0xF0 & 0x3C = 0x30.
        bus.rsp0_ready = 1'b0;
        set_req(0, 1'b1, 5'h03, 8'hF0, 8'h3C, 8'h00);
        set_req(1, 1'b1, 5'h01, 8'h01, 8'h01, 8'h00);
        #1;
        check("bp_ready0", bus.req0_ready, 1);
        check("bp_ready1_lose", bus.req1_ready, 0);
        @(negedge clk);
        set_req(0, 1'b0, 5'h00, 8'h00, 8'h00, 8'h00);
        #1;
        check("bp_exec_ready1", bus.req1_ready, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("bp_rsp0_valid", bus.rsp0_valid, 1);
            check("bp_rsp0_data", bus.rsp0_data, 8'h30);
            check("bp_rsp0_err", bus.rsp0_err, 0);
            check("bp_ready1", bus.req1_ready, 0);
            check("bp_state", dbg_state, 2);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("bp_rst_ready1", bus.req1_ready, 0);
        check("bp_alu_rst", bus.alu_rst, 0);
        @(negedge clk);
        check("bp_rst_rsp0_valid", bus.rsp0_valid, 0);
        check("bp_rst_state", dbg_state, 0);
        check("bp_rst_data", bus.rsp0_data, 0);
        rst = 1'b1;
        set_req(1, 1'b0, 5'h00, 8'h00, 8'h00, 8'h00);
        bus.rsp0_ready = 1'b1;
        @(negedge clk);
        check("bp_no_rsp0", bus.rsp0_valid, 0);
        check("bp_no_rsp1", bus.rsp1_valid, 0);
        check("bp_idle", dbg_state, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
